// File: rtl/diff_accum.sv
// Windowed accumulator: sums WIN_LEN signed 5-bit samples into an ACC_W-bit total.
// Define DIFF_ACCUM_SAT_EN for saturating adds with an overflow flag; default wraps.
module diff_accum #(
  parameter int WIN_LEN = 16,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       diffIn,
  input  logic             diffValid,
  output logic             diffReady,
  output logic [ACC_W-1:0] sumOut,
  output logic             ovfOut,
  output logic             outValid,
  input  logic             outReady
);

  localparam int CW = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             r_ready;
  logic             r_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_done;

  assign w_accept = diffValid && r_ready;
  assign w_last   = (r_cnt == CW'(WIN_LEN - 1));
  assign w_done   = (r_state == HOLD) && outReady;

`ifdef DIFF_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_ext;
  logic [ACC_W:0] w_sum;
  logic           w_clip;
  logic           r_ovf;
  logic           r_ovf_out;

  assign w_ext  = {{(ACC_W-4){diffIn[4]}}, diffIn};
  assign w_sum  = {r_acc[ACC_W-1], r_acc} + w_ext;
  // Sign bits disagree only when the true sum left the ACC_W range
  assign w_clip = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_clip) begin
      w_acc_nxt = w_sum[ACC_W] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (w_done) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= r_ovf | w_clip;
      if (w_last) begin
        r_ovf_out <= r_ovf | w_clip;
      end
    end
  end

  assign ovfOut = r_ovf_out;
`else
  logic [ACC_W-1:0] w_ext;

  assign w_ext     = {{(ACC_W-5){diffIn[4]}}, diffIn};
  assign w_acc_nxt = r_acc + w_ext;
  assign ovfOut    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (outReady) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != HOLD);
      r_valid <= (w_state_nxt == HOLD);
      if (w_done) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_sum <= w_acc_nxt;
        end
      end
    end
  end

  assign diffReady = r_ready;
  assign outValid  = r_valid;
  assign sumOut    = r_sum;

endmodule

// File: tb/tb_diff_accum.sv
// Directed bench for diff_accum with hand-computed window totals.
// Expected values follow DIFF_ACCUM_SAT_EN when it is defined.
module tb_diff_accum;

  logic       clk;
  logic       rst_n;
  logic [4:0] diffIn;
  logic       diffValid;
  logic       diffReady;
  logic [7:0] sumOut;
  logic       ovfOut;
  logic       outValid;
  logic       outReady;

  int n_chk;
  int n_err;

  diff_accum #(
    .WIN_LEN(16),
    .ACC_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .diffIn   (diffIn),
    .diffValid(diffValid),
    .diffReady(diffReady),
    .sumOut   (sumOut),
    .ovfOut   (ovfOut),
    .outValid (outValid),
    .outReady (outReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ssum();
    return int'($signed(sumOut));
  endfunction

  task automatic push(input int d);
    int n;
    n = 0;
    diffValid = 1'b1;
    diffIn    = 5'(d);
    while (!diffReady && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("ready_to", int'(diffReady), 1);
    tick();
    diffValid = 1'b0;
  endtask

  task automatic window(input int d);
    for (int i = 0; i < 16; i++) push(d);
  endtask

  task automatic drain();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("drain_v", int'(outValid), 0);
    chk("drain_r", int'(diffReady), 1);
  endtask

  initial begin
    int acc;
    int cyc;
    logic rdy;
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    diffIn    = '0;
    diffValid = 1'b0;
    outReady  = 1'b0;

    repeat (3) tick();
    chk("rst_ready", int'(diffReady), 0);
    chk("rst_valid", int'(outValid), 0);
    chk("rst_sum", ssum(), 0);
    chk("rst_ovf", int'(ovfOut), 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", int'(diffReady), 1);
    repeat (3) tick();
    chk("idle_valid", int'(outValid), 0);

    for (int i = 0; i < 15; i++) push((i % 2 == 0) ? 3 : -2);
    chk("pre_valid", int'(outValid), 0);
    push(-2);
    chk("basic_v", int'(outValid), 1);
    chk("basic_sum", ssum(), 8);
    chk("basic_ovf", int'(ovfOut), 0);
    chk("basic_rdy", int'(diffReady), 0);
    repeat (2) tick();
    chk("basic_rdy2", int'(diffReady), 0);
    drain();

    window(15);
    chk("pos_v", int'(outValid), 1);
`ifdef DIFF_ACCUM_SAT_EN
    chk("pos_sum", ssum(), 127);
    chk("pos_ovf", int'(ovfOut), 1);
`else
    chk("pos_sum", ssum(), -16);
    chk("pos_ovf", int'(ovfOut), 0);
`endif
    drain();

    window(-16);
`ifdef DIFF_ACCUM_SAT_EN
    chk("neg_sum", ssum(), -128);
    chk("neg_ovf", int'(ovfOut), 1);
`else
    chk("neg_sum", ssum(), 0);
    chk("neg_ovf", int'(ovfOut), 0);
`endif
    drain();

    acc = 0;
    cyc = 0;
    while (acc < 16 && cyc < 300) begin
      if ($urandom_range(0, 1) == 1) begin
        diffValid = 1'b1;
        diffIn    = 5'd1;
      end else begin
        diffValid = 1'b0;
        diffIn    = 5'($urandom);
      end
      rdy = diffReady;
      tick();
      if (diffValid && rdy) acc++;
      cyc++;
    end
    diffValid = 1'b0;
    chk("hs_accepts", acc, 16);
    chk("hs_v", int'(outValid), 1);
    chk("hs_sum", ssum(), 16);
    for (int i = 0; i < 5; i++) begin
      diffValid = (i % 2 == 0);
      diffIn    = 5'd15;
      tick();
      chk("hold_v", int'(outValid), 1);
      chk("hold_sum", ssum(), 16);
      chk("hold_rdy", int'(diffReady), 0);
    end
    diffValid = 1'b0;
    drain();
    window(-1);
    chk("next_sum", ssum(), -16);
    drain();

    for (int i = 0; i < 7; i++) push(4);
    rst_n = 1'b0;
    tick();
    chk("mrst_rdy", int'(diffReady), 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_rdy2", int'(diffReady), 1);
    chk("mrst_v", int'(outValid), 0);
    window(1);
    chk("mrst_sum", ssum(), 16);
    chk("mrst_v2", int'(outValid), 1);

    rst_n = 1'b0;
    tick();
    chk("hrst_v", int'(outValid), 0);
    chk("hrst_sum", ssum(), 0);
    rst_n = 1'b1;
    tick();
    window(2);
    chk("final_sum", ssum(), 32);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/diff_accum.md
# diff_accum

Windowed accumulator placed directly downstream of the sequential subtractor. It consumes the subtractor's signed 5-bit difference stream through a valid/ready handshake and sums WIN_LEN accepted samples into a signed ACC_W-bit total. It presents the total on a held output handshake, then clears and starts the next window. The result feeds the statistics/threshold logic that follows the arithmetic datapath.

## Interface
- WIN_LEN, 16: samples per window; legal range 2..16.
- ACC_W, 8: accumulator/result width in bits, signed; legal range 6..12.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- diffIn  in  5  signed difference sample, -16..+15.
- diffValid  in  1  diffIn is valid this cycle.
- diffReady  out  1  block can accept a sample; registered.
- sumOut  out  ACC_W  signed window total; registered.
- ovfOut  out  1  window total left the ACC_W signed range; registered.
- outValid  out  1  sumOut/ovfOut are valid; registered.
- outReady  in  1  downstream accepts the result.

## Operation
- Reset (rst_n sampled low at an edge) sets:
  - state IDLE; acc = 0, cnt = 0, ovf = 0.
  - diffReady = 0, outValid = 0, sumOut = 0, ovfOut = 0.
- The first edge with rst_n high sets diffReady = 1.
- Input accept: diffValid && diffReady at an edge.
  - diffIn is sign-extended to ACC_W+1 bits and added to acc.
  - cnt increments on each accept.
- FSM states:
  - IDLE (cnt = 0): on accept go to ACCUM. With WIN_LEN = 2, a single accept never completes a window, so IDLE never goes directly to HOLD.
  - ACCUM (1 <= cnt < WIN_LEN): an accept that makes cnt = WIN_LEN goes to HOLD. Otherwise stay.
  - HOLD: diffReady = 0, outValid = 1. sumOut and ovfOut hold the final values and stay stable until outValid && outReady. On that edge: outValid = 0, acc = 0, cnt = 0, ovf = 0, diffReady = 1, go to IDLE.
- No accept means no state change. diffIn is don't-care when diffValid = 0.
- diffValid asserted while diffReady = 0 is ignored; the upstream must keep holding the sample.
- sumOut and ovfOut keep the previous window's values while not in HOLD. They are only meaningful when outValid = 1.
- Reset during any state, including HOLD with outValid = 1, aborts and discards the partial or pending window.

## Timing
- Input throughput: one sample per cycle while diffReady = 1.
- Window latency: the edge accepting sample WIN_LEN raises outValid at that same edge.
  - Result is visible in the cycle right after the last accept.
  - diffReady drops at that same edge.
- Output handoff: outReady high in the first HOLD cycle lowers outValid and raises diffReady at the next edge. This gives exactly one HOLD cycle per window.
- Minimum window period: WIN_LEN + 1 cycles.
- outReady is not required to wait for outValid. outReady outside HOLD has no effect.

## Configuration
- DIFF_ACCUM_SAT_EN defined (saturating mode):
  - Each add is computed at ACC_W+1 bits.
  - Results above 2^(ACC_W-1)-1 clamp to that maximum; results below -2^(ACC_W-1) clamp to that minimum.
  - Any clamp sets ovf, which stays set until the window is consumed or reset.
  - ovfOut = ovf.
- DIFF_ACCUM_SAT_EN undefined (wrapping mode):
  - Adds wrap modulo 2^ACC_W (two's complement).
  - The ovf logic is not built; ovfOut is constant 0.

## Test plan
- Reset and idle: hold rst_n low 3 cycles, release.
  - During reset: all outputs 0.
  - First edge with rst_n high: diffReady = 1.
  - No outValid without input.
- Basic window (defaults), 16 back-to-back samples alternating +3, -2:
  - outValid rises the cycle after the 16th accept.
  - sumOut = 8, ovfOut = 0.
  - diffReady = 0 until outReady.
- Positive overflow, 16 × +15 (raw total 240):
  - With DIFF_ACCUM_SAT_EN: sumOut = 127, ovfOut = 1.
  - Without: sumOut = -16, ovfOut = 0.
- Negative overflow, 16 × -16 (raw total -256):
  - With DIFF_ACCUM_SAT_EN: sumOut = -128, ovfOut = 1.
  - Without: sumOut = 0.
- Handshake stress:
  - Input: diffValid toggles randomly while diffIn changes on cycles where diffValid = 0. 16 accepts of +1 give sumOut = 16.
  - Output: outReady held low 5 cycles. outValid and sumOut stay stable, and diffValid pulses during HOLD are ignored.
  - Next window then sums from 0.
- Mid-operation reset:
  - Reset after 7 accepts of +4: state IDLE, and the next full window of 16 × +1 gives sumOut = 16.
  - Reset during HOLD: outValid = 0 at the reset edge.
